// File: rtl/register_file.sv
// ============================================================================
// register_file : 2**ADDR_WIDTH x DATA_WIDTH GPR file, 2 async read / 1 sync
// write, entry 0 hardwired to zero. Option macro: REGISTER_FILE_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  write
);

  localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_ENTRIES];
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_ra_array;
  logic [DATA_WIDTH-1:0] w_rb_array;

  assign w_wr_en = write && !reset && (wr_addr != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign w_ra_array = (ra_addr == '0) ? '0 : mem_q[ra_addr];
  assign w_rb_array = (rb_addr == '0) ? '0 : mem_q[rb_addr];

`ifdef REGISTER_FILE_BYPASS_EN
  // w_wr_en already excludes reset cycles and address 0.
  assign ra_data = (w_wr_en && (wr_addr == ra_addr)) ? wr_data : w_ra_array;
  assign rb_data = (w_wr_en && (wr_addr == rb_addr)) ? wr_data : w_rb_array;
`else
  assign ra_data = w_ra_array;
  assign rb_data = w_rb_array;
`endif

endmodule

`default_nettype wire
